// File: rtl/banco_registradores_if.sv
// Register bank bus: write port, PC control, two read ports and PC status.
//   master : drives clear/wr_en/wr_addr/buswire/pc_incr/rd_addr_a/rd_addr_b
//   slave  : returns rd_data_a/rd_data_b/pc_out/pc_wrap
interface banco_registradores_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
);
  logic              clear;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  buswire;
  logic              pc_incr;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [WIDTH-1:0]  rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  rd_data_b;
  logic [WIDTH-1:0]  pc_out;
  logic              pc_wrap;

  modport master (
    output clear, wr_en, wr_addr, buswire, pc_incr, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, pc_out, pc_wrap
  );

  modport slave (
    input  clear, wr_en, wr_addr, buswire, pc_incr, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, pc_out, pc_wrap
  );
endinterface

// File: rtl/banco_registradores.sv
// Parametrised register bank; register PC_IDX doubles as program counter.
// State updates on the falling edge of clock so a rising-edge control FSM
// always samples settled register values.
// Ports:
//   clock  : system clock (state updates on negedge)
//   resetn : asynchronous active-low reset, clears all state
//   bus    : banco_registradores_if.slave (write port, pc_incr, clear,
//            two combinational read ports, pc_out, registered pc_wrap)
// Optional feature: define BANCO_BYPASS_EN for write-through forwarding of
// buswire to the read ports and pc_out (register update is unchanged).
module banco_registradores #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned PC_IDX   = 7
) (
  input  logic                    clock,
  input  logic                    resetn,
  banco_registradores_if.slave    bus
);

  // Elaboration-time configuration check
  if ((NUM_REGS != (32'd1 << ADDR_W)) || (PC_IDX >= NUM_REGS)) begin : g_bad_cfg
    $error("banco_registradores: NUM_REGS must be 2**ADDR_W and PC_IDX < NUM_REGS");
  end

  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  logic [NUM_REGS-1:0][WIDTH-1:0] regs_q;
  logic [NUM_REGS-1:0][WIDTH-1:0] regs_nxt;
  logic                           wrap_q;
  logic                           wrap_nxt;
  logic                           wr_pc;

  assign wr_pc = bus.wr_en && (bus.wr_addr == PC_ADDR);

  // Next state: clear > write (to PC wins over incr) > pc_incr > hold
  always_comb begin
    regs_nxt = regs_q;
    wrap_nxt = wrap_q;
    if (bus.clear) begin
      regs_nxt = '0;
      wrap_nxt = 1'b0;
    end else begin
      if (bus.wr_en) begin
        regs_nxt[bus.wr_addr] = bus.buswire;
      end
      if (bus.pc_incr) begin
        if (wr_pc) begin
          wrap_nxt = 1'b0;
        end else begin
          regs_nxt[PC_IDX] = regs_q[PC_IDX] + WIDTH'(1);
          wrap_nxt         = &regs_q[PC_IDX];
        end
      end
    end
  end

  // State register, falling-edge clocked
  always_ff @(negedge clock or negedge resetn) begin
    if (!resetn) begin
      regs_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      regs_q <= regs_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  // Read ports
`ifdef BANCO_BYPASS_EN
  assign bus.rd_data_a = (bus.wr_en && (bus.wr_addr == bus.rd_addr_a)) ?
                         bus.buswire : regs_q[bus.rd_addr_a];
  assign bus.rd_data_b = (bus.wr_en && (bus.wr_addr == bus.rd_addr_b)) ?
                         bus.buswire : regs_q[bus.rd_addr_b];
  assign bus.pc_out    = wr_pc ? bus.buswire : regs_q[PC_IDX];
`else
  assign bus.rd_data_a = regs_q[bus.rd_addr_a];
  assign bus.rd_data_b = regs_q[bus.rd_addr_b];
  assign bus.pc_out    = regs_q[PC_IDX];
`endif
  assign bus.pc_wrap   = wrap_q;

endmodule
